// File: rtl/toothless_pkg.sv
// Shared types and constants for the toothless core front end.
// Holds the fetch FSM state encoding and the PC increment.
package toothless_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD
    } fetch_state_e;

    localparam int FETCH_INCR = 4;
    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Pair of saturating event counters for fetch stall cycles and redirect flushes.
// Only present in builds with FETCH_PERF_CNT_EN defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_inc_i,
    input  logic        flush_inc_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);
    import toothless_pkg::*;

    logic [PERF_CNT_W-1:0] stall_cnt_q;
    logic [PERF_CNT_W-1:0] flush_cnt_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc_i && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, one outstanding req/gnt/rvalid request,
// holds the word for decode and applies redirects. FETCH_PERF_CNT_EN adds perf counters.
//
// state      | meaning
// FETCH_IDLE | first cycle after reset release, no request
// FETCH_REQ  | request driven, waiting for grant
// FETCH_WAIT | granted, waiting for read data
// FETCH_HOLD | instruction presented to decode
module fetch_ctrl #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr_i,
    output logic                   instr_req_o,
    output logic [ADDR_WIDTH-1:0]  instr_addr_o,
    input  logic                   instr_gnt_i,
    input  logic                   instr_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] instr_rdata_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic [ADDR_WIDTH-1:0]  pc_plus4_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_stall_cnt_o,
    output logic [31:0]            fetch_flush_cnt_o
`endif
);
    import toothless_pkg::*;

    fetch_state_e           state_q;
    logic [ADDR_WIDTH-1:0]  fetch_addr_q;
    logic [ADDR_WIDTH-1:0]  pending_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   valid_q;
    logic                   discard_q;

    logic [ADDR_WIDTH-1:0]  redirect_tgt;
    logic [ADDR_WIDTH-1:0]  fetch_addr_aligned;
    logic [ADDR_WIDTH-1:0]  fetch_addr_next;
    logic                   unused_redirect_lsb;

    // Targets are forced word aligned; the low bits of the target are dropped.
    assign redirect_tgt        = {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_addr_i[1:0];
    assign fetch_addr_aligned  = {fetch_addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign fetch_addr_next     = fetch_addr_aligned + ADDR_WIDTH'(FETCH_INCR);

    // HOLD issues the next request in the same cycle the decoder accepts.
    always_comb begin
        instr_req_o = 1'b0;
        if (state_q == FETCH_REQ) begin
            instr_req_o = 1'b1;
        end else if (state_q == FETCH_HOLD) begin
            instr_req_o = instr_ready_i && !redirect_i;
        end
    end

    assign instr_addr_o  = fetch_addr_aligned;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + ADDR_WIDTH'(FETCH_INCR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH_IDLE;
            fetch_addr_q <= BOOT_ADDR;
            pending_q    <= BOOT_ADDR;
            pc_q         <= BOOT_ADDR;
            instr_q      <= '0;
            valid_q      <= 1'b0;
            discard_q    <= 1'b0;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    state_q <= FETCH_REQ;
                    if (redirect_i) begin
                        fetch_addr_q <= redirect_tgt;
                    end
                end
                FETCH_REQ: begin
                    // The address on the bus must not move before grant, so a
                    // redirect here only marks the eventual response stale.
                    if (redirect_i) begin
                        pending_q <= redirect_tgt;
                        discard_q <= 1'b1;
                    end
                    if (instr_gnt_i) begin
                        state_q <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (instr_rvalid_i) begin
                        if (discard_q || redirect_i) begin
                            discard_q    <= 1'b0;
                            fetch_addr_q <= redirect_i ? redirect_tgt : pending_q;
                            state_q      <= FETCH_REQ;
                        end else begin
                            instr_q      <= instr_rdata_i;
                            pc_q         <= fetch_addr_aligned;
                            fetch_addr_q <= fetch_addr_next;
                            valid_q      <= 1'b1;
                            state_q      <= FETCH_HOLD;
                        end
                    end else if (redirect_i) begin
                        pending_q <= redirect_tgt;
                        discard_q <= 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect_i) begin
                        valid_q      <= 1'b0;
                        fetch_addr_q <= redirect_tgt;
                        state_q      <= FETCH_REQ;
                    end else if (instr_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= instr_gnt_i ? FETCH_WAIT : FETCH_REQ;
                    end
                end
                default: begin
                    state_q <= FETCH_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = ((state_q == FETCH_REQ) && !instr_gnt_i) ||
                       ((state_q == FETCH_WAIT) && !instr_rvalid_i);
    // In IDLE nothing is in flight yet, so a redirect there flushes nothing.
    assign flush_inc = redirect_i && (state_q != FETCH_IDLE);

    fetch_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_inc_i (stall_inc),
        .flush_inc_i (flush_inc),
        .stall_cnt_o (fetch_stall_cnt_o),
        .flush_cnt_o (fetch_flush_cnt_o)
    );
`else
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed cycle table, reset-during-WAIT sequence and a
// randomized run against a program-order reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_stall_cnt_o;
    logic [31:0] fetch_flush_cnt_o;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .BOOT_ADDR   (32'h0000_0100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_stall_cnt_o (fetch_stall_cnt_o),
        .fetch_flush_cnt_o (fetch_flush_cnt_o)
`endif
    );

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] raddr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs [NVEC];

    int n_total = 0;
    int n_pass  = 0;

    function automatic vec_t mk(logic g, logic rv, logic [31:0] rd, logic rdy, logic rr,
                                logic [31:0] ra, logic er, logic [31:0] ea, logic ev,
                                logic [31:0] ep, logic [31:0] ei);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.redir = rr; v.raddr = ra;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] p;
        p = a * 32'h9E37_79B1;
        return p ^ 32'h5A5A_0000;
    endfunction

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rr, input logic [31:0] ra);
        instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd;
        instr_ready_i = rdy; redirect_i = rr; redirect_addr_i = ra;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [31:0] exp_pc, out_addr, prev_addr;
    logic        outstanding, rv_real, prev_req, prev_gnt;
    int          countdown, delivered;

    initial begin
        vecs[0]  = mk(0,0,32'h0,   0,0,32'h0,       0,32'h0,   0,32'h100,32'h0);
        vecs[1]  = mk(1,0,32'h0,   0,0,32'h0,       1,32'h100, 0,32'h100,32'h0);
        vecs[2]  = mk(0,1,32'h13,  0,0,32'h0,       0,32'h0,   0,32'h100,32'h0);
        vecs[3]  = mk(1,0,32'h0,   1,0,32'h0,       1,32'h104, 1,32'h100,32'h13);
        vecs[4]  = mk(0,1,32'h93,  1,0,32'h0,       0,32'h0,   0,32'h100,32'h13);
        vecs[5]  = mk(0,0,32'h0,   1,0,32'h0,       1,32'h108, 1,32'h104,32'h93);
        vecs[6]  = mk(0,0,32'h0,   0,0,32'h0,       1,32'h108, 0,32'h104,32'h93);
        vecs[7]  = mk(0,0,32'h0,   0,0,32'h0,       1,32'h108, 0,32'h104,32'h93);
        vecs[8]  = mk(1,0,32'h0,   0,0,32'h0,       1,32'h108, 0,32'h104,32'h93);
        vecs[9]  = mk(0,0,32'h0,   0,0,32'h0,       0,32'h0,   0,32'h104,32'h93);
        vecs[10] = mk(0,1,32'hAB,  0,0,32'h0,       0,32'h0,   0,32'h104,32'h93);
        vecs[11] = mk(0,0,32'h0,   0,0,32'h0,       0,32'h0,   1,32'h108,32'hAB);
        vecs[12] = mk(0,0,32'h0,   0,0,32'h0,       0,32'h0,   1,32'h108,32'hAB);
        vecs[13] = mk(0,0,32'h0,   0,0,32'h0,       0,32'h0,   1,32'h108,32'hAB);
        vecs[14] = mk(0,0,32'h0,   0,0,32'h0,       0,32'h0,   1,32'h108,32'hAB);
        vecs[15] = mk(1,0,32'h0,   1,0,32'h0,       1,32'h10C, 1,32'h108,32'hAB);
        vecs[16] = mk(0,0,32'h0,   0,1,32'h200,     0,32'h0,   0,32'h108,32'hAB);
        vecs[17] = mk(0,1,32'hDEAD,0,0,32'h0,       0,32'h0,   0,32'h108,32'hAB);
        vecs[18] = mk(1,0,32'h0,   0,0,32'h0,       1,32'h200, 0,32'h108,32'hAB);
        vecs[19] = mk(0,1,32'h55,  0,0,32'h0,       0,32'h0,   0,32'h108,32'hAB);
        vecs[20] = mk(0,0,32'h0,   1,0,32'h0,       1,32'h204, 1,32'h200,32'h55);
        vecs[21] = mk(0,0,32'h0,   0,1,32'h301,     1,32'h204, 0,32'h200,32'h55);
        vecs[22] = mk(0,0,32'h0,   0,0,32'h0,       1,32'h204, 0,32'h200,32'h55);
        vecs[23] = mk(1,0,32'h0,   0,0,32'h0,       1,32'h204, 0,32'h200,32'h55);
        vecs[24] = mk(0,1,32'h77,  0,0,32'h0,       0,32'h0,   0,32'h200,32'h55);
        vecs[25] = mk(1,0,32'h0,   0,0,32'h0,       1,32'h300, 0,32'h200,32'h55);
        vecs[26] = mk(0,1,32'h99,  0,0,32'h0,       0,32'h0,   0,32'h200,32'h55);
        vecs[27] = mk(0,0,32'h0,   1,1,32'hFFFF_FFFC,0,32'h0,  1,32'h300,32'h99);
        vecs[28] = mk(1,0,32'h0,   0,0,32'h0,       1,32'hFFFF_FFFC,0,32'h300,32'h99);
        vecs[29] = mk(0,1,32'h11,  0,0,32'h0,       0,32'h0,   0,32'h300,32'h99);
        vecs[30] = mk(1,0,32'h0,   1,0,32'h0,       1,32'h0,   1,32'hFFFF_FFFC,32'h11);
        vecs[31] = mk(0,1,32'h22,  1,0,32'h0,       0,32'h0,   0,32'hFFFF_FFFC,32'h11);
        vecs[32] = mk(0,0,32'h0,   0,0,32'h0,       0,32'h0,   1,32'h0,32'h22);

        // Directed table: one row per cycle starting at the IDLE cycle.
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata,
                  vecs[i].ready, vecs[i].redir, vecs[i].raddr);
            @(negedge clk);
            chk($sformatf("row%0d req", i), {31'b0, instr_req_o}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk($sformatf("row%0d addr", i), instr_addr_o, vecs[i].e_addr);
            chk($sformatf("row%0d valid", i), {31'b0, instr_valid_o}, {31'b0, vecs[i].e_valid});
            chk($sformatf("row%0d pc", i), pc_o, vecs[i].e_pc);
            chk($sformatf("row%0d instr", i), instr_o, vecs[i].e_instr);
            chk($sformatf("row%0d pc_plus4", i), pc_plus4_o, vecs[i].e_pc + 32'd4);
            @(posedge clk);
            #1;
        end

        // Reset asserted while a response is outstanding; late rvalid must be ignored.
        drive(1, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst req", {31'b0, instr_req_o}, 32'd0);
        chk("rst valid", {31'b0, instr_valid_o}, 32'd0);
        chk("rst pc", pc_o, 32'h100);
        chk("rst instr", instr_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst stall_cnt", fetch_stall_cnt_o, 32'h0);
        chk("rst flush_cnt", fetch_flush_cnt_o, 32'h0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        drive(0, 1, 32'hBAD0_BAD0, 1, 0, 0);
        @(negedge clk);
        chk("post-rst idle req", {31'b0, instr_req_o}, 32'd0);
        @(posedge clk); #1;
        drive(0, 1, 32'hBAD1_BAD1, 1, 0, 0);
        @(negedge clk);
        chk("post-rst req", {31'b0, instr_req_o}, 32'd1);
        chk("post-rst addr", instr_addr_o, 32'h100);
        chk("post-rst valid", {31'b0, instr_valid_o}, 32'd0);
        @(posedge clk); #1;
        drive(1, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        drive(0, 1, 32'h0000_0005, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post-rst deliver valid", {31'b0, instr_valid_o}, 32'd1);
        chk("post-rst deliver pc", pc_o, 32'h100);
        chk("post-rst deliver instr", instr_o, 32'h5);

        // Randomized run against a program-order model.
        do_reset();
        exp_pc = 32'h100; outstanding = 0; out_addr = 0; countdown = 0;
        prev_req = 0; prev_gnt = 0; prev_addr = 0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            instr_ready_i = ($urandom % 4) != 0;
            redirect_i    = ($urandom % 14) == 0;
            case ($urandom % 4)
                0:       redirect_addr_i = 32'hFFFF_FFF0 + ($urandom % 16);
                1:       redirect_addr_i = $urandom;
                default: redirect_addr_i = $urandom % 32'h400;
            endcase
            rv_real = outstanding && (countdown == 0);
            if (rv_real) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = memf(out_addr);
            end else if (!outstanding && ($urandom % 6) == 0) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = $urandom;
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = $urandom;
            end
            #1;
            instr_gnt_i = instr_req_o && (($urandom % 3) != 0);
            @(negedge clk);
            chk("one outstanding", {31'b0, outstanding && instr_req_o}, 32'd0);
            if (prev_req && !prev_gnt) begin
                chk("req held", {31'b0, instr_req_o}, 32'd1);
                chk("addr held", instr_addr_o, prev_addr);
            end
            if (instr_req_o)
                chk("addr aligned", {30'b0, instr_addr_o[1:0]}, 32'd0);
            if (instr_valid_o) begin
                chk("rand pc_plus4", pc_plus4_o, pc_o + 32'd4);
                chk("rand instr", instr_o, memf(pc_o));
            end
            if (redirect_i) begin
                exp_pc = {redirect_addr_i[31:2], 2'b00};
            end else if (instr_valid_o && instr_ready_i) begin
                chk("rand pc order", pc_o, exp_pc);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (rv_real) outstanding = 1'b0;
            else if (outstanding) countdown--;
            if (instr_req_o && instr_gnt_i) begin
                outstanding = 1'b1;
                out_addr    = instr_addr_o;
                countdown   = $urandom_range(0, 2);
            end
            prev_req  = instr_req_o;
            prev_gnt  = instr_gnt_i;
            prev_addr = instr_addr_o;
            @(posedge clk);
            #1;
        end
        chk("rand progress", {31'b0, delivered > 100}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
